multicycle_adder: RTL

//  Parametrised multi-cycle ripple adder/subtractor: the successor to the 1-bit full adder cell.

---
 rtl/multicycle_adder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_adder.sv
// ============================================================================
// Module      : multicycle_adder
// Description : Multi-cycle ripple adder/subtractor, CHUNK bits per cycle,
//               LSB slice first, with valid/ready operand and result handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] c_LAST = KW'(N - 1);

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
            $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_a_q, w_a_d;
    logic [WIDTH-1:0] r_b_q, w_b_d;
    logic [WIDTH-1:0] r_s_q, w_s_d;
    logic             r_carry_q, w_carry_d;
    logic [KW-1:0]    r_k_q, w_k_d;
    logic             r_in_ready_q, w_in_ready_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic             r_cout_q, w_cout_d;
    logic             r_ovf_q, w_ovf_d;
    logic             r_zero_q, w_zero_d;

    logic [CHUNK-1:0] w_a_slice;
    logic [CHUNK-1:0] w_b_slice;
    logic [CHUNK:0]   w_slice_sum;

    // Slice selected by the counter; b is already inverted for subtraction.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < N; i++) begin
            if (r_k_q == KW'(i)) begin
                w_a_slice = r_a_q[i*CHUNK +: CHUNK];
                w_b_slice = r_b_q[i*CHUNK +: CHUNK];
            end
        end
        w_slice_sum = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_carry_q};
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_a_d         = r_a_q;
        w_b_d         = r_b_q;
        w_s_d         = r_s_q;
        w_carry_d     = r_carry_q;
        w_k_d         = r_k_q;
        w_in_ready_d  = r_in_ready_q;
        w_out_valid_d = r_out_valid_q;
        w_cout_d      = r_cout_q;
        w_ovf_d       = r_ovf_q;
        w_zero_d      = r_zero_q;
        case (r_state_q)
            S_IDLE: begin
                if (in_valid && r_in_ready_q) begin
                    w_a_d        = a;
                    w_b_d        = b ^ {WIDTH{sub}};
                    w_carry_d    = sub ? 1'b1 : cin;
                    w_k_d        = '0;
                    w_in_ready_d = 1'b0;
                    w_state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int i = 0; i < N; i++) begin
                    if (r_k_q == KW'(i)) begin
                        w_s_d[i*CHUNK +: CHUNK] = w_slice_sum[CHUNK-1:0];
                    end
                end
                w_carry_d = w_slice_sum[CHUNK];
                w_k_d     = r_k_q + 1'b1;
                if (r_k_q == c_LAST) begin
                    // Carry into the MSB recovered from the MSB sum bit.
                    w_cout_d      = w_slice_sum[CHUNK];
                    w_ovf_d       = (r_a_q[WIDTH-1] ^ r_b_q[WIDTH-1] ^ w_s_d[WIDTH-1])
                                    ^ w_slice_sum[CHUNK];
                    w_zero_d      = (w_s_d == '0);
                    w_out_valid_d = 1'b1;
                    w_state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_in_ready_d  = 1'b1;
                    w_state_d     = S_IDLE;
                end
            end
            default: begin
                w_out_valid_d = 1'b0;
                w_in_ready_d  = 1'b1;
                w_state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_s_q         <= '0;
            r_carry_q     <= 1'b0;
            r_k_q         <= '0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
            r_cout_q      <= 1'b0;
            r_ovf_q       <= 1'b0;
            r_zero_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_s_q         <= w_s_d;
            r_carry_q     <= w_carry_d;
            r_k_q         <= w_k_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_cout_q      <= w_cout_d;
            r_ovf_q       <= w_ovf_d;
            r_zero_q      <= w_zero_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign s         = r_s_q;
    assign cout      = r_cout_q;
    assign ovf       = r_ovf_q;
    assign zero      = r_zero_q;

endmodule

`default_nettype wire
